bcd_convert_arbiter: RTL and testbench

//  Shares one iterative (shift-add-3) binary-to-BCD converter among several requesters
//  (score, hi-score, level, timer) that feed the on-screen digit renderers.

---
 rtl/bcd_convert_arbiter_pkg.sv | 24 ++
 rtl/bcd_dabble_seq.sv | 64 ++++++
 rtl/bcd_convert_arbiter.sv | 118 +++++++++++
 tb/tb_bcd_convert_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_convert_arbiter_pkg.sv
// Shared types and constants for the shared binary-to-BCD converter.
// No logic of its own; the digit-adjust helper is purely combinational.
// No flow control here.
package bcd_convert_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_BIN_W  = 24;
  localparam int DEF_DIGITS = 6;

  // Every nibble of a saturated result carries this value.
  localparam logic [3:0] SAT_NIBBLE = 4'h9;

  // Double-dabble correction: a digit of 5..9 gets +3 so the next shift carries.
  function automatic logic [3:0] dabble_adj(input logic [3:0] d);
    return (d > 4'd4) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// Iterative shift-add-3 binary-to-BCD core, one operand bit per cycle.
// Latency: BIN_W cycles after start; last is high during the final shift cycle.
// No backpressure: start reloads unconditionally, caller sequences it.
module bcd_dabble_seq
  import bcd_convert_arbiter_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      operand,
  output logic [DIGITS*4-1:0]   digits,
  output logic                  ovf,
  output logic                  last
);

  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  logic [BIN_W-1:0]    shreg;
  logic [DIGITS*4-1:0] dig_q;
  logic [DIGITS*4-1:0] adj;
  logic [CW-1:0]       cnt;
  logic                run;
  logic                ovf_q;

  // Apply +3 correction to every digit before this cycle's shift.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[i*4 +: 4] = dabble_adj(dig_q[i*4 +: 4]);
    end
  end

  // Load on start, then shift {digits,shreg} left once per cycle; a bit leaving
  // the top digit means the value no longer fits in DIGITS digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      dig_q <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      ovf_q <= 1'b0;
    end else if (start) begin
      shreg <= operand;
      dig_q <= '0;
      cnt   <= CW'(BIN_W - 1);
      run   <= 1'b1;
      ovf_q <= 1'b0;
    end else if (run) begin
      dig_q <= {adj[DIGITS*4-2:0], shreg[BIN_W-1]};
      shreg <= {shreg[BIN_W-2:0], 1'b0};
      ovf_q <= ovf_q | adj[DIGITS*4-1];
      cnt   <= cnt - CW'(1);
      if (cnt == '0) run <= 1'b0;
    end
  end

  assign digits = dig_q;
  assign ovf    = ovf_q;
  assign last   = run && (cnt == '0);

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin share of one iterative BCD converter among N_REQ requesters.
// Latency: ack 1 cycle after grant, done BIN_W+1 cycles after ack.
// Backpressure: requesters hold req/bin_in until ack; others wait while busy.
module bcd_convert_arbiter
  import bcd_convert_arbiter_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*BIN_W-1:0]  bin_in,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        done,
  output logic [DIGITS*4-1:0]     bcd_out,
  output logic                    ovf,
  output logic                    busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t              state, state_nxt;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       gidx;
  logic [PW-1:0]       gnt_idx;
  logic                gnt_any;
  logic                start;
  int                  rr_j;
  logic [BIN_W-1:0]    operand;
  logic [DIGITS*4-1:0] dig;
  logic                dig_ovf;
  logic                last;

  // Pick the first active request at or after the pointer, wrapping around.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_j    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_j = int'(ptr) + k;
      if (rr_j >= N_REQ) rr_j = rr_j - N_REQ;
      if (!gnt_any && req[rr_j]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(rr_j);
      end
    end
  end

  assign operand = bin_in[int'(gnt_idx)*BIN_W +: BIN_W];

  bcd_dabble_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_dabble (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .operand (operand),
    .digits  (dig),
    .ovf     (dig_ovf),
    .last    (last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state; a grant is only taken while idle so a holder cannot re-win early.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes, result register, busy flag and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack     <= '0;
      done    <= '0;
      bcd_out <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      ptr     <= '0;
      gidx    <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      if (|done) busy <= 1'b0;
      if (start) begin
        ack[gnt_idx] <= 1'b1;
        gidx         <= gnt_idx;
        busy         <= 1'b1;
      end
      if (state == DONE) begin
        done[gidx] <= 1'b1;
        bcd_out    <= dig_ovf ? {DIGITS{SAT_NIBBLE}} : dig;
        ovf        <= dig_ovf;
        if (gidx == PW'(N_REQ - 1)) ptr <= '0;
        else                        ptr <= gidx + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Scoreboard bench for the shared BCD converter arbiter.
// Expected grants/results are queued at stimulus time and popped on done.
// Requesters hold req until ack, as the interface requires.
module tb_bcd_convert_arbiter;

  localparam int N_REQ  = 4;
  localparam int BIN_W  = 24;
  localparam int DIGITS = 6;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*BIN_W-1:0] bin_in = '0;
  logic [N_REQ-1:0]       ack, done;
  logic [DIGITS*4-1:0]    bcd_out;
  logic                   ovf, busy;

  bcd_convert_arbiter #(.N_REQ(N_REQ), .BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .bin_in  (bin_in),
    .ack     (ack),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [23:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   ack_cyc = 0;
  bit   inconv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nvec++;
    if (obs !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference conversion by division, saturating above 999999.
  function automatic void model(input logic [23:0] v, output logic [23:0] b, output logic o);
    int x;
    x = int'(v);
    b = '0;
    o = 1'b0;
    if (x > 999999) begin
      b = 24'h999999;
      o = 1'b1;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        b[i*4 +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
  endfunction

  task automatic push_exp(input int idx, input logic [23:0] val);
    exp_t e;
    logic [23:0] b;
    logic o;
    model(val, b, o);
    e.idx = idx;
    e.bcd = b;
    e.ovf = o;
    sbq.push_back(e);
  endtask

  // Monitor: busy tracking, ack order against queue head, result and latency on done.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      inconv = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'((|ack) | inconv));
      if (|ack) begin
        ack_cyc = cyc;
        if (sbq.size() == 0) chk("ack_unexp", 32'(ack), 32'd0);
        else                 chk("ack_idx", 32'(ack), 32'(1) << sbq[0].idx);
        inconv = 1'b1;
      end
      if (|done) begin
        if (sbq.size() == 0) begin
          chk("done_unexp", 32'(done), 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("done_idx", 32'(done), 32'(1) << mon_e.idx);
          chk("bcd_out", 32'(bcd_out), 32'(mon_e.bcd));
          chk("ovf", 32'(ovf), 32'(mon_e.ovf));
          chk("done_lat", 32'(cyc - ack_cyc), 32'd25);
        end
        inconv = 1'b0;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},  32'(ack),     32'd0);
    chk({tag, "_done"}, 32'(done),    32'd0);
    chk({tag, "_bcd"},  32'(bcd_out), 32'd0);
    chk({tag, "_ovf"},  32'(ovf),     32'd0);
    chk({tag, "_busy"}, 32'(busy),    32'd0);
  endtask

  task automatic wait_ack(input int idx, output int n);
    n = 0;
    while (!ack[idx] && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done(input int idx);
    int n;
    n = 0;
    while (!done[idx] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done[idx]), 32'd1);
  endtask

  // One request on an idle arbiter: ack must follow on the next cycle.
  task automatic serve(input int idx, input logic [23:0] val);
    int n;
    push_exp(idx, val);
    bin_in[idx*BIN_W +: BIN_W] = val;
    req[idx] = 1'b1;
    wait_ack(idx, n);
    chk("ack_lat", 32'(n), 32'd1);
    req[idx] = 1'b0;
    wait_done(idx);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs(tag);
    sbq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int acks;

    #1;
    chk_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic conversions, zero, max fitting value, overflow cases.
    serve(0, 24'd123456);
    serve(1, 24'd0);
    serve(2, 24'd999999);
    serve(3, 24'd1000000);
    serve(0, 24'hFFFFFF);
    for (int r = 0; r < 3; r++) begin
      serve(r + 1, 24'($urandom_range(0, 1200000)));
    end

    // A one-cycle req pulse while busy is never granted.
    push_exp(0, 24'd4321);
    bin_in[0 +: BIN_W] = 24'd4321;
    req[0] = 1'b1;
    wait_ack(0, n);
    req[0] = 1'b0;
    repeat (5) @(negedge clk);
    bin_in[0 +: BIN_W] = 24'd7777;
    req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    wait_done(0);
    repeat (40) @(negedge clk);
    chk("pulse_sb_empty", 32'(sbq.size()), 32'd0);

    // Reset in the middle of a conversion discards it; pending req[2] served after.
    push_exp(0, 24'd654321);
    bin_in[0 +: BIN_W] = 24'd654321;
    req[0] = 1'b1;
    wait_ack(0, n);
    req[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    sbq.delete();
    bin_in[2*BIN_W +: BIN_W] = 24'd42;
    req = 4'b0100;
    push_exp(2, 24'd42);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ack(2, n);
    chk("ack_after_rst", 32'(n), 32'd1);
    req = '0;
    wait_done(2);
    repeat (40) @(negedge clk);
    chk("rst_sb_empty", 32'(sbq.size()), 32'd0);

    // Round-robin with all requests held: order 0,1,2,3,0.
    do_reset("rst2");
    bin_in = {24'd44, 24'd33, 24'd22, 24'd11};
    push_exp(0, 24'd11);
    push_exp(1, 24'd22);
    push_exp(2, 24'd33);
    push_exp(3, 24'd44);
    push_exp(0, 24'd11);
    req = 4'b1111;
    acks = 0;
    n = 0;
    while (acks < 5 && n < 400) begin
      @(negedge clk);
      n++;
      if (|ack) acks++;
    end
    req = '0;
    chk("rr_acks", 32'(acks), 32'd5);
    repeat (40) @(negedge clk);
    chk("rr_sb_empty", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
